// File: rtl/simon_datapath.sv
// Simon game datapath: stores the growing pattern sequence, steps through it
// for playback and the end-of-game display, checks player repeats against it,
// and reports status flags back to the control FSM. One clock = one step.
module simon_datapath #(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level,
    input  logic [3:0] pattern,
    input  logic       w_en,
    input  logic [1:0] sel,
    input  logic       clr_cnt,
    output logic       is_legal,
    output logic       play_eq_count,
    output logic       repeat_eq_play,
    output logic       input_eq_pattern,
    output logic [3:0] pattern_leds
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] SEL_PLAYBACK = 2'b00;
    localparam logic [1:0] SEL_REPEAT   = 2'b01;
    localparam logic [1:0] SEL_DONE     = 2'b10;

    // True when exactly one of the four pattern bits is set.
    function automatic logic one_hot(input logic [3:0] p);
        return (p == 4'b0001) || (p == 4'b0010) || (p == 4'b0100) || (p == 4'b1000);
    endfunction

    logic [3:0]    mem_r [DEPTH];
    logic [CW-1:0] count_r;
    logic [PW-1:0] play_ptr_r;
    logic [PW-1:0] rep_ptr_r;
    logic          level_r;

    logic [PW-1:0] last_s;
    logic          empty_s;
    logic          is_legal_s;
    logic          play_last_s;
    logic          rep_last_s;
    logic          match_s;
    logic [PW-1:0] play_next_s;
    logic [PW-1:0] rep_next_s;
    logic          wr_en_s;
    logic [3:0]    leds_s;

    // Index of the newest stored entry; pinned to 0 when nothing is stored.
    always_comb begin
        empty_s = (count_r == CW'(0));
        if (empty_s) begin
            last_s = '0;
        end else begin
            last_s = PW'(count_r - CW'(1));
        end
    end

    // Status flags and wrapping pointer increments.
    always_comb begin
        is_legal_s  = (count_r != CW'(DEPTH)) && (pattern != 4'b0000) &&
                      (level_r || one_hot(pattern));
        play_last_s = (play_ptr_r == last_s);
        rep_last_s  = (rep_ptr_r == last_s);
        match_s     = (pattern == mem_r[rep_ptr_r]);
        if (play_last_s) begin
            play_next_s = '0;
        end else begin
            play_next_s = play_ptr_r + PW'(1);
        end
        if (rep_last_s) begin
            rep_next_s = '0;
        end else begin
            rep_next_s = rep_ptr_r + PW'(1);
        end
        wr_en_s = !rst && !clr_cnt && w_en && is_legal_s;
    end

    // LED source: live pattern while entering/repeating, stored entry while showing.
    always_comb begin
        leds_s = 4'b0000;
        if (w_en) begin
            leds_s = pattern;
        end else begin
            case (sel)
                SEL_PLAYBACK, SEL_DONE: begin
                    if (empty_s) begin
                        leds_s = 4'b0000;
                    end else begin
                        leds_s = mem_r[play_ptr_r];
                    end
                end
                SEL_REPEAT: leds_s = pattern;
                default:    leds_s = 4'b0000;
            endcase
        end
    end

    assign is_legal         = is_legal_s;
    assign play_eq_count    = play_last_s;
    assign repeat_eq_play   = rep_last_s;
    assign input_eq_pattern = match_s;
    assign pattern_leds     = leds_s;

    // Pattern storage; contents survive reset and clear, only count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[count_r[PW-1:0]] <= pattern;
        end
    end

    // Count, pointers and latched difficulty level.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= '0;
            play_ptr_r <= '0;
            rep_ptr_r  <= '0;
            level_r    <= level;
        end else if (clr_cnt) begin
            count_r    <= '0;
            play_ptr_r <= '0;
            rep_ptr_r  <= '0;
        end else if (w_en) begin
            if (is_legal_s) begin
                count_r <= count_r + CW'(1);
            end
            play_ptr_r <= '0;
            rep_ptr_r  <= '0;
        end else begin
            case (sel)
                SEL_PLAYBACK: begin
                    play_ptr_r <= play_next_s;
                    rep_ptr_r  <= '0;
                end
                SEL_REPEAT: begin
                    play_ptr_r <= '0;
                    if (match_s) begin
                        rep_ptr_r <= rep_next_s;
                    end
                end
                SEL_DONE: begin
                    play_ptr_r <= play_next_s;
                end
                default: begin
                    play_ptr_r <= play_ptr_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath: a vector table for the main sequence on a
// DEPTH=64 instance, plus a hand-written full-memory sequence on a DEPTH=4 instance.
module tb_simon_datapath;

    logic       clk;
    logic       rst;
    logic       level;
    logic [3:0] pattern;
    logic       w_en;
    logic [1:0] sel;
    logic       clr_cnt;

    logic       is_legal, play_eq_count, repeat_eq_play, input_eq_pattern;
    logic [3:0] pattern_leds;
    logic       is_legal4, play_eq_count4, repeat_eq_play4, input_eq_pattern4;
    logic [3:0] pattern_leds4;

    int total = 0;
    int bad   = 0;

    simon_datapath dut (
        .clk(clk), .rst(rst), .level(level), .pattern(pattern), .w_en(w_en),
        .sel(sel), .clr_cnt(clr_cnt), .is_legal(is_legal),
        .play_eq_count(play_eq_count), .repeat_eq_play(repeat_eq_play),
        .input_eq_pattern(input_eq_pattern), .pattern_leds(pattern_leds)
    );

    simon_datapath #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .level(level), .pattern(pattern), .w_en(w_en),
        .sel(sel), .clr_cnt(clr_cnt), .is_legal(is_legal4),
        .play_eq_count(play_eq_count4), .repeat_eq_play(repeat_eq_play4),
        .input_eq_pattern(input_eq_pattern4), .pattern_leds(pattern_leds4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       lvl;
        logic [3:0] pat;
        logic       wen;
        logic [1:0] sel;
        logic       clr;
        logic       e_leg;
        logic       e_pec;
        logic       e_rep;
        logic       m_iep;
        logic       e_iep;
        logic [3:0] e_led;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic l, input logic [3:0] p, input logic we,
                     input logic [1:0] s, input logic c, input logic leg, input logic pec,
                     input logic rep, input logic miep, input logic iep, input logic [3:0] led);
        vec_t t;
        t = '{r, l, p, we, s, c, leg, pec, rep, miep, iep, led};
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] wr [5];

        // rst lvl pat wen sel clr | leg pec rep miep iep led
        v(0,0,4'b0011,1,2'b11,0, 0,1,1, 0,0,4'b0011); // level 0: non one-hot rejected
        v(0,0,4'b0000,0,2'b00,0, 0,1,1, 0,0,4'b0000); // count still 0: playback dark
        v(0,0,4'b0100,1,2'b11,0, 1,1,1, 0,0,4'b0100); // one-hot accepted
        v(0,0,4'b0000,0,2'b00,0, 0,1,1, 1,0,4'b0100); // count 1: shows mem[0]
        v(0,0,4'b0110,1,2'b11,0, 0,1,1, 1,0,4'b0110);
        v(1,1,4'b0000,0,2'b11,0, 0,1,1, 1,0,4'b0000); // reset with level=1
        v(0,0,4'b0011,1,2'b11,0, 1,1,1, 1,0,4'b0011); // level_r held at 1
        v(0,0,4'b1000,1,2'b11,0, 1,1,1, 1,0,4'b1000);
        v(0,0,4'b0110,1,2'b11,0, 1,0,0, 1,0,4'b0110);
        v(0,0,4'b0000,0,2'b00,0, 0,0,0, 1,0,4'b0011); // playback of 3 entries
        v(0,0,4'b0000,0,2'b00,0, 0,0,0, 1,0,4'b1000);
        v(0,0,4'b0000,0,2'b00,0, 0,1,0, 1,0,4'b0110);
        v(0,0,4'b0000,0,2'b00,0, 0,0,0, 1,0,4'b0011); // wrapped to 0
        v(0,0,4'b0011,0,2'b01,0, 1,0,0, 1,1,4'b0011); // repeat
        v(0,0,4'b1000,0,2'b01,0, 1,0,0, 1,1,4'b1000);
        v(0,0,4'b0110,0,2'b01,0, 1,0,1, 1,1,4'b0110);
        v(0,0,4'b0011,0,2'b01,0, 1,0,0, 1,1,4'b0011);
        v(0,0,4'b0001,0,2'b01,0, 1,0,0, 1,0,4'b0001); // wrong entry at ptr 1
        v(0,0,4'b0001,0,2'b01,0, 1,0,0, 1,0,4'b0001); // rep_ptr held
        v(0,0,4'b1000,0,2'b01,0, 1,0,0, 1,1,4'b1000);
        v(0,0,4'b0110,0,2'b01,0, 1,0,1, 1,1,4'b0110);
        v(0,0,4'b0001,1,2'b00,1, 1,0,0, 1,0,4'b0001); // clear beats legal write
        v(0,0,4'b0000,0,2'b00,0, 0,1,1, 1,0,4'b0000); // count back to 0
        v(0,0,4'b0011,0,2'b01,0, 1,1,1, 1,1,4'b0011); // mem kept, reachable at ptr 0
        v(0,0,4'b0101,1,2'b11,0, 1,1,1, 1,0,4'b0101);
        v(0,0,4'b1010,1,2'b11,0, 1,1,1, 1,0,4'b1010);
        v(0,0,4'b0000,0,2'b10,0, 0,0,0, 1,0,4'b0101); // done: alternate
        v(0,0,4'b0000,0,2'b10,0, 0,1,0, 1,0,4'b1010);
        v(0,0,4'b0000,0,2'b10,0, 0,0,0, 1,0,4'b0101);
        v(0,0,4'b0000,0,2'b10,0, 0,1,0, 1,0,4'b1010);
        v(0,0,4'b0000,0,2'b10,0, 0,0,0, 1,0,4'b0101);
        v(0,0,4'b0000,0,2'b11,0, 0,1,0, 1,0,4'b0000); // idle: dark, frozen
        v(0,0,4'b0000,0,2'b11,0, 0,1,0, 1,0,4'b0000);
        v(0,0,4'b0000,0,2'b10,0, 0,1,0, 1,0,4'b1010); // play_ptr still 1
        v(0,0,4'b0000,0,2'b00,0, 0,0,0, 1,0,4'b0101);
        v(1,0,4'b0000,0,2'b00,0, 0,1,0, 1,0,4'b1010); // reset mid-playback, level=0
        v(0,1,4'b0000,0,2'b00,0, 0,1,1, 1,0,4'b0000);
        v(0,1,4'b0011,1,2'b11,0, 0,1,1, 1,0,4'b0011); // level_r reloaded to 0
        v(0,1,4'b1000,1,2'b11,0, 1,1,1, 1,0,4'b1000);
        v(0,1,4'b0000,0,2'b00,0, 0,1,1, 1,0,4'b1000);

        rst = 1'b1; level = 1'b0; pattern = 4'b0000; w_en = 1'b0; sel = 2'b11; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = vq[i].rst; level = vq[i].lvl; pattern = vq[i].pat;
            w_en = vq[i].wen; sel = vq[i].sel; clr_cnt = vq[i].clr;
            #1;
            chk("is_legal", i, {3'b000, is_legal}, {3'b000, vq[i].e_leg});
            chk("play_eq_count", i, {3'b000, play_eq_count}, {3'b000, vq[i].e_pec});
            chk("repeat_eq_play", i, {3'b000, repeat_eq_play}, {3'b000, vq[i].e_rep});
            chk("pattern_leds", i, pattern_leds, vq[i].e_led);
            if (vq[i].m_iep) begin
                chk("input_eq_pattern", i, {3'b000, input_eq_pattern}, {3'b000, vq[i].e_iep});
            end
        end

        // DEPTH=4 instance: fill, overflow attempt, then playback of exactly 4 entries.
        wr[0] = 4'b0001; wr[1] = 4'b0010; wr[2] = 4'b0100; wr[3] = 4'b1000; wr[4] = 4'b1111;
        @(negedge clk);
        rst = 1'b1; level = 1'b1; pattern = 4'b0000; w_en = 1'b0; sel = 2'b11; clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = 1'b0; w_en = 1'b1; pattern = wr[i];
            #1;
            chk("full_is_legal", i, {3'b000, is_legal4}, {3'b000, (i < 4) ? 1'b1 : 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            w_en = 1'b0; sel = 2'b00; pattern = 4'b0000;
            #1;
            chk("full_play_leds", i, pattern_leds4, wr[i % 4]);
            chk("full_play_eq", i, {3'b000, play_eq_count4}, {3'b000, (i == 3) ? 1'b1 : 1'b0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
